// File: rtl/arith_pkg.sv
// Shared opcode encodings and FSM state type for the sequential arithmetic unit.
package arith_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/arith_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH iterations.
// The last iteration is folded combinationally into product so the result is ready as done rises.
module arith_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 ack,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 active;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign done    = active && (cnt == LAST);
  assign product = acc_nxt;

  // control: count saturates at LAST until the top takes the product
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      if (done) begin
        if (ack) active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // datapath: frozen while waiting on the consumer
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (active && !done) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Handshaked arithmetic unit: single-cycle ALU ops plus an iterative multiply,
// with a registered result/flag stage that holds under consumer backpressure.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [2:0]       op_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t state, state_nxt;

  logic               out_free;
  logic               accept;
  logic               pop;
  logic               mul_start;
  logic               alu_load;
  logic               mul_load;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_o;

  // accept stage
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign mul_start = accept && (op_sel == OP_MUL);
  assign alu_load  = accept && (op_sel != OP_MUL);
  assign mul_load  = (state == MUL) && mul_done && out_free;
  assign busy      = (state == MUL);

  assign sum   = {1'b0, data_1} + {1'b0, data_2};
  assign diff  = {1'b0, data_1} - {1'b0, data_2};
  assign shamt = data_2[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (data_1[M] == data_2[M]) && (sum[M] != data_1[M]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_o   = (data_1[M] != data_2[M]) && (diff[M] != data_1[M]);
      end
      OP_AND:  alu_res = data_1 & data_2;
      OP_OR:   alu_res = data_1 | data_2;
      OP_XOR:  alu_res = data_1 ^ data_2;
      OP_SHL:  alu_res = data_1 << shamt;
      OP_SHR:  alu_res = data_1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  arith_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .ack     (out_free),
    .a       (data_1),
    .b       (data_2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_load)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (alu_load) begin
      data_out   <= alu_res;
      flag_zero  <= (alu_res == '0);
      flag_carry <= alu_c;
      flag_ovf   <= alu_o;
      out_valid  <= 1'b1;
    end else if (mul_load) begin
      data_out   <= mul_product[WIDTH-1:0];
      flag_zero  <= (mul_product[WIDTH-1:0] == '0);
      flag_carry <= 1'b0;
      flag_ovf   <= |mul_product[2*WIDTH-1:WIDTH];
      out_valid  <= 1'b1;
    end else if (pop) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
